// File: rtl/mouse_init_seq.sv
// PS/2 mouse power-up sequencer: reset, self-test wait, sample rate, resolution, stream enable.
// Define MOUSE_RETRY_EN to resend NAKed or timed-out bytes up to MAX_RETRY times before aborting.
module mouse_init_seq #(
  parameter logic [7:0]  SAMPLE_RATE = 8'd100,
  parameter logic [7:0]  RESOLUTION  = 8'd2,
  parameter int unsigned TIMEOUT_CYC = 25_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic       wr_ps2,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       stream_en,
  output logic       init_err,
  output logic [2:0] err_step
);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_RATE   = 8'hF3;
  localparam logic [7:0] CMD_RES    = 8'hE8;
  localparam logic [7:0] CMD_STREAM = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_NAK    = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  localparam logic [2:0] LAST_IDX = 3'd5;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_ACK,
    WAIT_BAT,
    WAIT_ID,
    STREAM,
    ERROR
  } state_t;

  state_t        state, state_next;
  logic [2:0]    index, index_next;
  logic [TW-1:0] timer;
  logic          timed_out;
  logic          take_retry;
  logic          retry_exhausted;

  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    rom_byte = CMD_RESET;
      3'd1:    rom_byte = CMD_RATE;
      3'd2:    rom_byte = SAMPLE_RATE;
      3'd3:    rom_byte = CMD_RES;
      3'd4:    rom_byte = RESOLUTION;
      3'd5:    rom_byte = CMD_STREAM;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  assign timed_out = (timer == TIMER_LAST);

  // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    index_next = index;
    take_retry = 1'b0;

    case (state)
      IDLE, STREAM, ERROR: begin
        if (start) begin
          state_next = SEND;
          index_next = '0;
        end
      end

      SEND: state_next = WAIT_TX;

      // Bytes arriving before the transmit completes are stale and dropped.
      WAIT_TX: begin
        if (tx_done_tick)   state_next = WAIT_ACK;
        else if (timed_out) take_retry = 1'b1;
      end

      WAIT_ACK: begin
        if (rx_done_tick) begin
          if (rx_data == RSP_ACK) begin
            if (index == 3'd0)          state_next = WAIT_BAT;
            else if (index == LAST_IDX) state_next = STREAM;
            else begin
              index_next = index + 3'd1;
              state_next = SEND;
            end
          end else if (rx_data == RSP_NAK) begin
            take_retry = 1'b1;
          end else begin
            state_next = ERROR;
          end
        end else if (timed_out) begin
          take_retry = 1'b1;
        end
      end

      WAIT_BAT: begin
        if (rx_done_tick)   state_next = (rx_data == RSP_BAT_OK) ? WAIT_ID : ERROR;
        else if (timed_out) take_retry = 1'b1;
      end

      WAIT_ID: begin
        if (rx_done_tick) begin
          if (rx_data == RSP_ID) begin
            index_next = 3'd1;
            state_next = SEND;
          end else begin
            state_next = ERROR;
          end
        end else if (timed_out) begin
          take_retry = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    // A received byte has already been handled above, so it always wins over a timeout.
    if (take_retry) state_next = retry_exhausted ? ERROR : SEND;
  end

  // NOTE: all state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (state_next != state) begin
      timer <= '0;
    end else if (state == WAIT_TX || state == WAIT_ACK ||
                 state == WAIT_BAT || state == WAIT_ID) begin
      timer <= timer + TW'(1);
    end
  end

`ifdef MOUSE_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RW-1:0] retry_cnt;

  // Any entry to SEND that is not a resend starts a fresh byte with a clean count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry_cnt <= '0;
    end else if (state_next == SEND) begin
      retry_cnt <= take_retry ? retry_cnt + RW'(1) : '0;
    end
  end

  assign retry_exhausted = (retry_cnt == RW'(MAX_RETRY));
`else
  assign retry_exhausted = 1'b1;
`endif

  // tx_byte stays put outside SEND entry, which holds it through the acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_byte <= '0;
    end else if (state_next == SEND) begin
      tx_byte <= rom_byte(index_next);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_step <= '0;
    end else if (state_next == ERROR && state != ERROR) begin
      err_step <= index;
    end
  end

  assign wr_ps2    = (state == SEND);
  assign busy      = (state == SEND) || (state == WAIT_TX) || (state == WAIT_ACK) ||
                     (state == WAIT_BAT) || (state == WAIT_ID);
  assign stream_en = (state == STREAM);
  assign init_err  = (state == ERROR);

endmodule

// File: tb/tb_mouse_init_seq.sv
// Bench for mouse_init_seq: a mouse model replies to each transmitted byte and a script-level
// reference predicts the byte sequence and the outcome (stream or abort step).
module tb_mouse_init_seq;

  localparam logic [7:0] SR  = 8'd100;
  localparam logic [7:0] RES = 8'd2;
  localparam int         TO  = 16;
  localparam int         MR  = 3;
`ifdef MOUSE_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] tx_byte;
  logic       busy;
  logic       stream_en;
  logic       init_err;
  logic [2:0] err_step;

  int errors = 0;
  int checks = 0;

  logic [7:0] script [6] = '{8'hFF, 8'hF3, SR, 8'hE8, RES, 8'hF4};

  mouse_init_seq #(
    .SAMPLE_RATE(SR),
    .RESOLUTION (RES),
    .TIMEOUT_CYC(TO),
    .MAX_RETRY  (MR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rx_data     (rx_data),
    .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick),
    .wr_ps2      (wr_ps2),
    .tx_byte     (tx_byte),
    .busy        (busy),
    .stream_en   (stream_en),
    .init_err    (init_err),
    .err_step    (err_step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    check({tag, " init_err cleared"}, 32'(init_err), 32'd0);
    check({tag, " stream_en cleared"}, 32'(stream_en), 32'd0);
  endtask

  task automatic expect_error(input string tag, input int step);
    check({tag, " init_err"}, 32'(init_err), 32'd1);
    check({tag, " err_step"}, 32'(err_step), 32'(step));
    check({tag, " busy idle"}, 32'(busy), 32'd0);
    check({tag, " no stream"}, 32'(stream_en), 32'd0);
    check({tag, " no wr"}, 32'(wr_ps2), 32'd0);
  endtask

  task automatic expect_stream(input string tag);
    check({tag, " stream_en"}, 32'(stream_en), 32'd1);
    check({tag, " busy done"}, 32'(busy), 32'd0);
    check({tag, " no error"}, 32'(init_err), 32'd0);
    check({tag, " no wr"}, 32'(wr_ps2), 32'd0);
  endtask

  // Mouse model plus script-level reference: predicts every transmitted byte and the end result.
  task automatic run_script(input string tag, input int nak_idx, input int nak_n,
                            input int bad_idx, input logic [7:0] bad_byte,
                            input logic [7:0] bat_byte, input int late_idx, input bit fast);
    int         idx     = 0;
    int         retries = 0;
    int         naks    = 0;
    bit         done    = 1'b0;
    logic [7:0] reply;
    do_start(tag);
    while (!done) begin
      check({tag, " wr pulse"}, 32'(wr_ps2), 32'd1);
      check({tag, " tx_byte"}, 32'(tx_byte), 32'(script[idx]));
      tick();
      check({tag, " wr one cycle"}, 32'(wr_ps2), 32'd0);
      check({tag, " tx_byte held"}, 32'(tx_byte), 32'(script[idx]));
      if (!fast) begin
        repeat ($urandom_range(0, 6)) begin
          if ($urandom_range(0, 3) == 0) pulse_rx(8'($urandom));
          else tick();
        end
      end
      pulse_tx();
      if (idx == late_idx) repeat (TO - 1) tick();
      else if (!fast) repeat ($urandom_range(0, 6)) tick();
      if (idx == 5) check({tag, " stream before last ack"}, 32'(stream_en), 32'd0);
      if (idx == nak_idx && naks < nak_n) begin
        reply = 8'hFE;
        naks++;
      end else if (idx == bad_idx) begin
        reply = bad_byte;
      end else begin
        reply = 8'hFA;
      end
      pulse_rx(reply);
      if (reply == 8'hFE) begin
        if (RETRY_EN && retries < MR) begin
          retries++;
        end else begin
          expect_error(tag, idx);
          done = 1'b1;
        end
      end else if (reply != 8'hFA) begin
        expect_error(tag, idx);
        done = 1'b1;
      end else if (idx == 0) begin
        check({tag, " busy in self-test"}, 32'(busy), 32'd1);
        if (!fast) repeat ($urandom_range(0, 6)) tick();
        pulse_rx(bat_byte);
        if (bat_byte != 8'hAA) begin
          expect_error(tag, 0);
          done = 1'b1;
        end else begin
          if (!fast) repeat ($urandom_range(0, 6)) tick();
          pulse_rx(8'h00);
          idx     = 1;
          retries = 0;
        end
      end else if (idx == 5) begin
        expect_stream(tag);
        done = 1'b1;
      end else begin
        idx++;
        retries = 0;
      end
    end
  endtask

  initial begin
    logic [7:0] bad;
    reset        = 1'b0;
    start        = 1'b0;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;

    #2;
    check("reset wr_ps2", 32'(wr_ps2), 32'd0);
    check("reset tx_byte", 32'(tx_byte), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset stream_en", 32'(stream_en), 32'd0);
    check("reset init_err", 32'(init_err), 32'd0);
    check("reset err_step", 32'(err_step), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_script("clean fast", -1, 0, -1, 8'h00, 8'hAA, -1, 1'b1);
    repeat (2) run_script("clean random", -1, 0, -1, 8'h00, 8'hAA, -1, 1'b0);
    run_script("ack at timeout", -1, 0, -1, 8'h00, 8'hAA, 2, 1'b0);
    run_script("nak E8 x2", 3, 2, -1, 8'h00, 8'hAA, -1, 1'b0);
    run_script("bat FC", -1, 0, -1, 8'h00, 8'hFC, -1, 1'b0);
    do bad = 8'($urandom); while (bad == 8'hFA || bad == 8'hFE);
    run_script("bad ack", -1, 0, $urandom_range(0, 5), bad, 8'hAA, -1, 1'b0);

    do_start("timeout");
    check("timeout first byte", 32'(tx_byte), 32'hFF);
    tick();
    repeat (TO - 1) tick();
    check("timeout not yet", 32'(init_err), 32'd0);
    check("timeout busy", 32'(busy), 32'd1);
    tick();
`ifdef MOUSE_RETRY_EN
    check("timeout resend wr", 32'(wr_ps2), 32'd1);
    check("timeout resend byte", 32'(tx_byte), 32'hFF);
    check("timeout resend no err", 32'(init_err), 32'd0);
`else
    expect_error("timeout", 0);
`endif
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    run_script("nak F3 limit", 1, MR + 1, -1, 8'h00, 8'hAA, -1, 1'b0);

    do_start("busy");
    check("busy first byte", 32'(tx_byte), 32'hFF);
    tick();
    pulse_tx();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start ignored wr", 32'(wr_ps2), 32'd0);
    check("start ignored busy", 32'(busy), 32'd1);
    check("start ignored byte", 32'(tx_byte), 32'hFF);
    pulse_rx(8'hFA);
    check("in bat wait busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async reset wr_ps2", 32'(wr_ps2), 32'd0);
    check("async reset tx_byte", 32'(tx_byte), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset stream_en", 32'(stream_en), 32'd0);
    check("async reset init_err", 32'(init_err), 32'd0);
    check("async reset err_step", 32'(err_step), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_script("restart", -1, 0, -1, 8'h00, 8'hAA, -1, 1'b0);

    repeat (4) tick();
    check("stream no further wr", 32'(wr_ps2), 32'd0);
    check("stream holds", 32'(stream_en), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
